vram_fill_buf: RTL
==================

// Module: vram_fill_buf
// PURPOSE
// - Parametrised single-clock frame-buffer RAM for the VGA path: one sync read port (display scan), one write port (painter).
// - Adds a hardware fill engine: one request paints every word with a colour, one word per clock.
// - Adds an address range check and a read-valid flag.
// - Sits between the drawing logic (write side) and the VGA timing/scan logic (read side).
// PARAMETERS
// - ADDR_W  15     address width, both ports
// - DATA_W  12     pixel word width (RGB444)
// - DEPTH   19200  number of implemented words (160x120); must be <= 2**ADDR_W
// PORTS
// - clk        in   1       system clock; all logic on the rising edge
// - rst        in   1       synchronous, active-high reset
// - raddr      in   ADDR_W  read address
// - rdata      out  DATA_W  read data, registered
// - rvalid     out  1       rdata corresponds to an in-range raddr sampled 1 cycle earlier
// - waddr      in   ADDR_W  write address
// - wdata      in   DATA_W  write data
// - we         in   1       write enable
// - clr_req    in   1       fill request, sampled high for 1 cycle
// - clr_color  in   DATA_W  fill colour, captured with clr_req
// - clr_busy   out  1       fill in progress
// - clr_done   out  1       1-cycle pulse after the last fill write
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values: rdata=0, rvalid=0, clr_busy=0, clr_done=0, FSM=IDLE, fill counter=0.
// - Reset does not clear memory contents.
// - Read path:
//   - rdata and rvalid are valid 1 cycle after raddr.
//   - raddr >= DEPTH: rdata=0, rvalid=0, no error.
// - Write path:
//   - Write occurs on the edge where we=1, FSM=IDLE and waddr < DEPTH.
//   - Any other we=1 is dropped silently: out of range, or FSM in FILL or DONE.
// - Read/write collision (same address, same cycle): read-first by default; rdata returns the old word. See CONFIGURATION.
// - Fill FSM states:
//   - IDLE: clr_req=1 -> FILL. On that cycle: latch clr_color, counter=0, clr_busy=1 from the next cycle.
//   - FILL: write the latched colour to mem[counter], then counter++.
//     - When counter == DEPTH-1 the write occurs and the FSM goes to DONE.
//     - Fill takes exactly DEPTH cycles of clr_busy=1.
//     - clr_req during FILL is ignored; the latched colour is not changed.
//   - DONE: clr_busy=0, clr_done=1 for one cycle, then unconditionally -> IDLE.
//     - A clr_req in DONE is ignored.
// - Reads are allowed in every state; mid-fill reads return a mix of old and new words.
// - Counter is ADDR_W bits wide and never wraps past DEPTH-1.
// - Reset during FILL: FSM to IDLE next edge. Already-written words keep the fill colour; the rest are unchanged. No clr_done pulse.
// - clr_req and we together in IDLE: the fill starts and the write in that cycle is still performed (FSM still IDLE on that edge).
// CONFIGURATION
// - Macro VRAM_BYPASS_EN.
//   - Defined: write-first forwarding. On a read/write collision with a performed write, rdata = wdata on the next cycle.
//     - A dropped write is not forwarded. Fill writes are forwarded the same way.
//   - Undefined: read-first; rdata returns the stored old word. No extra mux logic.
// TESTING
// - Reset, then read addr 0 -> rdata=0, rvalid=1 one cycle later.
// - Reset, then read addr 19200 -> rvalid=0, rdata=0.
// - Write 12'hABC @100, then read @100 -> rdata=12'hABC after 1 cycle.
// - Write 12'h123 @19200 (out of range) -> no memory change; read @0..19199 unchanged.
// - clr_req with clr_color=12'hF00:
//   - clr_busy high for exactly 19200 cycles, then clr_done pulses 1 cycle.
//   - Reads @0, @9600 and @19199 afterwards -> 12'hF00.
//   - we @5 mid-fill is dropped; word @5 stays 12'hF00.
// - Same-cycle write 12'h0F0 and read @42 over old value 12'h00F:
//   - Macro undefined -> rdata=12'h00F.
//   - Macro defined -> rdata=12'h0F0.
// - Fill 12'h0FF started, rst asserted at busy cycle 10:
//   - clr_busy=0 next cycle, no clr_done.
//   - Words @0..9 = 12'h0FF; word @10 and above keep their old values.

Source files
------------

// File: rtl/vram_fill_buf_if.sv
// Frame-buffer port bundle: scan read, painter write and fill control.
// master drives requests, slave (the RAM) returns data and fill status.
interface vram_fill_buf_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              clr_req;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output raddr, waddr, wdata, we,
    output clr_req, clr_color,
    input  rdata, rvalid, clr_busy, clr_done
  );

  modport slave (
    input  raddr, waddr, wdata, we,
    input  clr_req, clr_color,
    output rdata, rvalid, clr_busy, clr_done
  );
endinterface

// File: rtl/vram_fill_buf.sv
// VGA frame-buffer RAM with range-checked ports and a one-word-per-clock fill.
// Define VRAM_BYPASS_EN for write-first forwarding on read/write collisions.
module vram_fill_buf #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 19200
) (
  input logic            clk,
  input logic            rst,
  vram_fill_buf_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] color;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  logic              rd_in;
  logic              wr_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign rd_in = bus.raddr <= LAST;
  assign wr_in = bus.waddr <= LAST;

  // The fill engine owns the write port outside IDLE.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.waddr;
    mem_wdata = bus.wdata;
    if (!rst) begin
      unique case (state)
        FILL: begin
          mem_we    = 1'b1;
          mem_addr  = cnt;
          mem_wdata = color;
        end
        IDLE: mem_we = bus.we && wr_in;
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_in;
      if (!rd_in)
        rdata <= '0;
`ifdef VRAM_BYPASS_EN
      else if (mem_we && mem_addr == bus.raddr)
        rdata <= mem_wdata;
`endif
      else
        rdata <= mem[bus.raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      color <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= FILL;
            cnt   <= '0;
            color <= bus.clr_color;
            busy  <= 1'b1;
          end
        end
        FILL: begin
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata    = rdata;
  assign bus.rvalid   = rvalid;
  assign bus.clr_busy = busy;
  assign bus.clr_done = done;
endmodule
